// File: rtl/wb_commit_regfile_pkg.sv
// Shared constants for the write-back commit stage and the forwarding unit.
// The slot-priority constant must agree with the forwarding unit's bypass priority.
package wb_commit_regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 16;

    typedef enum logic {
        SLOT1 = 1'b0,
        SLOT2 = 1'b1
    } slot_e;

    // On a same-destination dual write, this slot's data lands in the array.
    localparam slot_e SLOT_PRIORITY = SLOT2;

    function automatic logic [1:0] write_count(input logic we1, input logic we2);
        return {1'b0, we1} + {1'b0, we2};
    endfunction

endpackage

// File: rtl/wb_commit_regfile_regfile_2w2r.sv
// Register array: two synchronous write ports, two combinational read ports, async clear.
module regfile_2w2r
    import wb_commit_regfile_pkg::*;
#(
    parameter int DATA_W = wb_commit_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_commit_regfile_pkg::ADDR_W,
    parameter int DEPTH  = wb_commit_regfile_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // The later non-blocking assignment wins, which implements the slot priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (SLOT_PRIORITY == SLOT2) begin
            if (we1) mem_q[wa1] <= wd1;
            if (we2) mem_q[wa2] <= wd2;
        end else begin
            if (we2) mem_q[wa2] <= wd2;
            if (we1) mem_q[wa1] <= wd1;
        end
    end

    assign rd1 = mem_q[ra1];
    assign rd2 = mem_q[ra2];

endmodule

// File: rtl/wb_commit_regfile.sv
// Dual-slot write-back commit stage feeding a 32x8 register file, plus a saturating commit counter.
module wb_commit_regfile
    import wb_commit_regfile_pkg::*;
#(
    parameter int DATA_W = wb_commit_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_commit_regfile_pkg::ADDR_W,
    parameter int DEPTH  = wb_commit_regfile_pkg::DEPTH,
    parameter int CNT_W  = wb_commit_regfile_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] memwb_rd1,
    input  logic [ADDR_W-1:0] memwb_rd2,
    input  logic              rgw1_wb,
    input  logic              rgw2_wb,
    input  logic [DATA_W-1:0] wb_data1,
    input  logic [DATA_W-1:0] wb_data2,
    input  logic [ADDR_W-1:0] rs_1,
    input  logic [ADDR_W-1:0] rs_2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [ADDR_W-1:0] reg_rd1,
    output logic [ADDR_W-1:0] reg_rd2,
    output logic              rgw1_reg,
    output logic              rgw2_reg,
    output logic [DATA_W-1:0] reg_data1,
    output logic [DATA_W-1:0] reg_data2,
    output logic [CNT_W-1:0]  commit_count
);

    logic [ADDR_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic              we1_q, we1_d, we2_q, we2_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              advance;
    logic [CNT_W:0]    cnt_sum;

    // Flush overrides stall: the held stage still retires before being cleared.
    assign advance = !stall || flush;

    always_comb begin
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        we1_d   = we1_q;
        we2_d   = we2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        cnt_d   = cnt_q;
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(write_count(we1_q, we2_q));

        if (advance) begin
            rd1_d   = memwb_rd1;
            rd2_d   = memwb_rd2;
            data1_d = wb_data1;
            data2_d = wb_data2;
            we1_d   = rgw1_wb && !flush;
            we2_d   = rgw2_wb && !flush;
            cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q   <= '0;
            rd2_q   <= '0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            cnt_q   <= '0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            we1_q   <= we1_d;
            we2_q   <= we2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            cnt_q   <= cnt_d;
        end
    end

    regfile_2w2r #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we1   (we1_q && advance),
        .wa1   (rd1_q),
        .wd1   (data1_q),
        .we2   (we2_q && advance),
        .wa2   (rd2_q),
        .wd2   (data2_q),
        .ra1   (rs_1),
        .ra2   (rs_2),
        .rd1   (rd_data1),
        .rd2   (rd_data2)
    );

    assign reg_rd1      = rd1_q;
    assign reg_rd2      = rd2_q;
    assign rgw1_reg     = we1_q;
    assign rgw2_reg     = we2_q;
    assign reg_data1    = data1_q;
    assign reg_data2    = data2_q;
    assign commit_count = cnt_q;

endmodule
